// File: rtl/mul_wb_if.sv
// Handshake bundle between the multiplier writeback stage and its neighbours:
// producer side (in_*), register-file write port (wb_*) and exception reporting (exc_*).
interface mul_wb_if #(
    parameter int N  = 16,
    parameter int AW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rd_addr;
    logic [N-1:0]  in_result;
    logic [N-1:0]  in_co;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [N-1:0]  wb_data;
    logic          exc_flag;
    logic [AW-1:0] exc_addr;
    logic          exc_clr;
    logic [7:0]    exc_count;

    // Environment view: drives results in, accepts writebacks, clears exceptions
    modport master (
        output in_valid, in_rd_addr, in_result, in_co, wb_ready, exc_clr,
        input  in_ready, wb_valid, wb_addr, wb_data, exc_flag, exc_addr, exc_count
    );

    // Writeback stage view
    modport slave (
        input  in_valid, in_rd_addr, in_result, in_co, wb_ready, exc_clr,
        output in_ready, wb_valid, wb_addr, wb_data, exc_flag, exc_addr, exc_count
    );
endinterface

// File: rtl/mul_wb.sv
// Multiplier writeback stage: 2-entry in-order queue toward the register file,
// with overflow results diverted into a sticky exception flag and saturating count.
module mul_wb #(
    parameter int N  = 16,
    parameter int AW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    mul_wb_if.slave     bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          head_q, head_d;
    logic          tail_q, tail_d;
    logic [AW-1:0] addr_mem_q [2];
    logic [N-1:0]  data_mem_q [2];
    logic          exc_flag_q, exc_flag_d;
    logic [AW-1:0] exc_addr_q, exc_addr_d;
    logic [7:0]    exc_count_q, exc_count_d;

    logic in_ready;
    logic wb_valid;
    logic accept;
    logic push;
    logic ovf;
    logic pop;

    // Ready depends only on registered occupancy so no in->out combinational path exists
    assign in_ready = (state_q != FULL);
    assign wb_valid = (state_q != EMPTY);
    assign accept   = bus.in_valid && in_ready;
    assign ovf      = accept && (bus.in_co != '0);
    assign push     = accept && (bus.in_co == '0);
    assign pop      = wb_valid && bus.wb_ready;

    assign bus.in_ready  = in_ready;
    assign bus.wb_valid  = wb_valid;
    assign bus.wb_addr   = wb_valid ? addr_mem_q[head_q] : '0;
    assign bus.wb_data   = wb_valid ? data_mem_q[head_q] : '0;
    assign bus.exc_flag  = exc_flag_q;
    assign bus.exc_addr  = exc_addr_q;
    assign bus.exc_count = exc_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            exc_flag_q  <= 1'b0;
            exc_addr_q  <= '0;
            exc_count_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            exc_flag_q  <= exc_flag_d;
            exc_addr_q  <= exc_addr_d;
            exc_count_q <= exc_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        head_d      = pop  ? ~head_q : head_q;
        tail_d      = push ? ~tail_q : tail_q;
        exc_flag_d  = exc_flag_q;
        exc_addr_d  = exc_addr_q;
        exc_count_d = exc_count_q;

        unique case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:  if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase

        // A new overflow beats a same-cycle clear and re-captures the address
        if (ovf) begin
            exc_flag_d = 1'b1;
            if (!exc_flag_q || bus.exc_clr) exc_addr_d = bus.in_rd_addr;
            if (exc_count_q != 8'hFF) exc_count_d = exc_count_q + 8'd1;
        end else if (bus.exc_clr) begin
            exc_flag_d = 1'b0;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                addr_mem_q[gi] <= '0;
                data_mem_q[gi] <= '0;
            end else if (push && (tail_q == 1'(gi))) begin
                addr_mem_q[gi] <= bus.in_rd_addr;
                data_mem_q[gi] <= bus.in_result;
            end
        end
    end
endmodule

// File: tb/tb_mul_wb.sv
// Directed-vector bench for mul_wb: queue ordering, backpressure, overflow
// exceptions, counter saturation and asynchronous reset.
module tb_mul_wb;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mul_wb_if #(.N(16), .AW(3)) bus ();

    mul_wb #(.N(16), .AW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [2:0] a, input logic [15:0] r, input logic [15:0] c);
        bus.in_valid   = v;
        bus.in_rd_addr = a;
        bus.in_result  = r;
        bus.in_co      = c;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_in(1'b0, 3'd0, 16'd0, 16'd0);
        bus.wb_ready = 1'b0;
        bus.exc_clr  = 1'b0;
        #3;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        tests++; if (bus.wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got=%0b exp=0", bus.wb_valid); end
        tests++; if (bus.wb_data !== 16'd0) begin fails++; $display("FAIL reset_wb_data got=%0d exp=0", bus.wb_data); end
        tests++; if (bus.exc_count !== 8'd0) begin fails++; $display("FAIL reset_exc_count got=%0d exp=0", bus.exc_count); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0 || bus.exc_flag !== 1'b0) begin
            fails++; $display("FAIL post_reset got ready=%0b valid=%0b flag=%0b exp 1 0 0", bus.in_ready, bus.wb_valid, bus.exc_flag);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_single;
        set_in(1'b1, 3'd3, 16'd42, 16'd0);
        @(negedge clk);
        set_in(1'b0, 3'd0, 16'd0, 16'd0);
        tests++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 3'd3 || bus.wb_data !== 16'd42) begin
            fails++; $display("FAIL single_out got v=%0b a=%0d d=%0d exp 1 3 42", bus.wb_valid, bus.wb_addr, bus.wb_data);
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        bus.wb_ready = 1'b0;
        tests++; if (bus.wb_valid !== 1'b0 || bus.wb_addr !== 3'd0 || bus.wb_data !== 16'd0) begin
            fails++; $display("FAIL single_pop got v=%0b a=%0d d=%0d exp 0 0 0", bus.wb_valid, bus.wb_addr, bus.wb_data);
        end
        $display("[TB] single r3=42 written back");
    endtask

    task automatic test_backpressure;
        bus.wb_ready = 1'b0;
        set_in(1'b1, 3'd1, 16'd5, 16'd0);
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b1 || bus.wb_data !== 16'd5) begin
            fails++; $display("FAIL bp_first got ready=%0b d=%0d exp 1 5", bus.in_ready, bus.wb_data);
        end
        set_in(1'b1, 3'd2, 16'd6, 16'd0);
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got=%0b exp=0", bus.in_ready); end
        set_in(1'b1, 3'd3, 16'd7, 16'd0);
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b0 || bus.wb_addr !== 3'd1 || bus.wb_data !== 16'd5) begin
            fails++; $display("FAIL bp_stall got ready=%0b a=%0d d=%0d exp 0 1 5", bus.in_ready, bus.wb_addr, bus.wb_data);
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        tests++; if (bus.wb_addr !== 3'd2 || bus.wb_data !== 16'd6 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_second got a=%0d d=%0d ready=%0b exp 2 6 1", bus.wb_addr, bus.wb_data, bus.in_ready);
        end
        @(negedge clk);
        set_in(1'b0, 3'd0, 16'd0, 16'd0);
        tests++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 3'd3 || bus.wb_data !== 16'd7) begin
            fails++; $display("FAIL bp_third got v=%0b a=%0d d=%0d exp 1 3 7", bus.wb_valid, bus.wb_addr, bus.wb_data);
        end
        @(negedge clk);
        bus.wb_ready = 1'b0;
        tests++; if (bus.wb_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got=%0b exp=0", bus.wb_valid); end
        $display("[TB] backpressure r1=5 r2=6 r3=7 in order");
    endtask

    task automatic test_overflow;
        set_in(1'b1, 3'd4, 16'd0, 16'd1);
        @(negedge clk);
        tests++; if (bus.wb_valid !== 1'b0 || bus.exc_flag !== 1'b1 || bus.exc_addr !== 3'd4 || bus.exc_count !== 8'd1) begin
            fails++; $display("FAIL ovf_first got v=%0b f=%0b a=%0d c=%0d exp 0 1 4 1", bus.wb_valid, bus.exc_flag, bus.exc_addr, bus.exc_count);
        end
        set_in(1'b1, 3'd6, 16'd0, 16'd2);
        @(negedge clk);
        set_in(1'b0, 3'd0, 16'd0, 16'd0);
        tests++; if (bus.exc_flag !== 1'b1 || bus.exc_addr !== 3'd4 || bus.exc_count !== 8'd2) begin
            fails++; $display("FAIL ovf_second got f=%0b a=%0d c=%0d exp 1 4 2", bus.exc_flag, bus.exc_addr, bus.exc_count);
        end
        $display("[TB] overflow exc_addr=%0d exc_count=%0d", bus.exc_addr, bus.exc_count);
    endtask

    task automatic test_exc_clr;
        bus.exc_clr = 1'b1;
        @(negedge clk);
        bus.exc_clr = 1'b0;
        tests++; if (bus.exc_flag !== 1'b0 || bus.exc_addr !== 3'd4) begin
            fails++; $display("FAIL clr_alone got f=%0b a=%0d exp 0 4", bus.exc_flag, bus.exc_addr);
        end
        set_in(1'b1, 3'd1, 16'd0, 16'h8000);
        @(negedge clk);
        tests++; if (bus.exc_flag !== 1'b1 || bus.exc_addr !== 3'd1 || bus.exc_count !== 8'd3) begin
            fails++; $display("FAIL clr_rearm got f=%0b a=%0d c=%0d exp 1 1 3", bus.exc_flag, bus.exc_addr, bus.exc_count);
        end
        set_in(1'b1, 3'd5, 16'd0, 16'd1);
        bus.exc_clr = 1'b1;
        @(negedge clk);
        bus.exc_clr = 1'b0;
        set_in(1'b0, 3'd0, 16'd0, 16'd0);
        tests++; if (bus.exc_flag !== 1'b1 || bus.exc_addr !== 3'd5 || bus.exc_count !== 8'd4) begin
            fails++; $display("FAIL clr_with_ovf got f=%0b a=%0d c=%0d exp 1 5 4", bus.exc_flag, bus.exc_addr, bus.exc_count);
        end
        $display("[TB] exc_clr checks exc_addr=%0d", bus.exc_addr);
    endtask

    task automatic test_saturate;
        set_in(1'b1, 3'd2, 16'd0, 16'd3);
        repeat (200) @(negedge clk);
        tests++; if (bus.exc_count !== 8'd204) begin fails++; $display("FAIL sat_mid got=%0d exp=204", bus.exc_count); end
        repeat (60) @(negedge clk);
        set_in(1'b0, 3'd0, 16'd0, 16'd0);
        tests++; if (bus.exc_count !== 8'd255 || bus.exc_addr !== 3'd5 || bus.wb_valid !== 1'b0) begin
            fails++; $display("FAIL sat_end got c=%0d a=%0d v=%0b exp 255 5 0", bus.exc_count, bus.exc_addr, bus.wb_valid);
        end
        $display("[TB] saturation exc_count=%0d", bus.exc_count);
    endtask

    task automatic test_push_pop;
        bus.wb_ready = 1'b0;
        set_in(1'b1, 3'd6, 16'd8, 16'd0);
        @(negedge clk);
        tests++; if (bus.wb_data !== 16'd8 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL pp_setup got d=%0d ready=%0b exp 8 1", bus.wb_data, bus.in_ready);
        end
        set_in(1'b1, 3'd7, 16'd9, 16'd0);
        bus.wb_ready = 1'b1;
        @(negedge clk);
        set_in(1'b0, 3'd0, 16'd0, 16'd0);
        bus.wb_ready = 1'b0;
        tests++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 3'd7 || bus.wb_data !== 16'd9 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL pp_same_cycle got v=%0b a=%0d d=%0d ready=%0b exp 1 7 9 1", bus.wb_valid, bus.wb_addr, bus.wb_data, bus.in_ready);
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        bus.wb_ready = 1'b0;
        tests++; if (bus.wb_valid !== 1'b0) begin fails++; $display("FAIL pp_drain got=%0b exp=0", bus.wb_valid); end
        $display("[TB] push+pop at occupancy 1 head r7=9");
    endtask

    task automatic test_reset_mid;
        set_in(1'b1, 3'd1, 16'd11, 16'd0);
        @(negedge clk);
        set_in(1'b1, 3'd2, 16'd22, 16'd0);
        @(negedge clk);
        set_in(1'b0, 3'd0, 16'd0, 16'd0);
        tests++; if (bus.wb_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.exc_count !== 8'd255) begin
            fails++; $display("FAIL rst_mid_pre got v=%0b ready=%0b c=%0d exp 1 0 255", bus.wb_valid, bus.in_ready, bus.exc_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== 16'd0 || bus.exc_count !== 8'd0 || bus.exc_flag !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_mid_async got v=%0b d=%0d c=%0d f=%0b ready=%0b exp 0 0 0 0 1", bus.wb_valid, bus.wb_data, bus.exc_count, bus.exc_flag, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (bus.wb_valid !== 1'b0 || bus.exc_addr !== 3'd0) begin
            fails++; $display("FAIL rst_mid_after got v=%0b a=%0d exp 0 0", bus.wb_valid, bus.exc_addr);
        end
        $display("[TB] asynchronous reset mid-stream");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_exc_clr();
        test_saturate();
        test_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_wb.md
# mul_wb

Writeback stage directly downstream of the combinational multiplier in the 16-bit CPU execute path. It captures the multiplier result (`mul_rd`), its carry-out (`m_co`) and the destination register address, buffers them in a 2-entry in-order queue, and presents them to the register-file write port through a valid/ready handshake. Results whose carry-out is non-zero are overflows: they are not written back, and instead raise a sticky exception flag with the offending address and a saturating exception count.

## Interface
- N, 16, data width; matches the multiplier's result and carry-out width
- AW, 3, register-file address width (8 registers)
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  multiplier result valid
- in_ready  output  N/A (1)  stage can accept this cycle
- in_rd_addr  input  AW  destination register
- in_result  input  N  multiplier product (`mul_rd`)
- in_co  input  N  multiplier carry-out (`m_co`); any non-zero value means overflow
- wb_valid  output  1  head entry available for write
- wb_ready  input  1  register file accepts the write this cycle
- wb_addr  output  AW  head entry register address; 0 when wb_valid=0
- wb_data  output  N  head entry data; 0 when wb_valid=0
- exc_flag  output  1  sticky overflow exception
- exc_addr  output  AW  in_rd_addr of the first overflow since the last clear
- exc_clr  input  1  clears exc_flag (single-cycle pulse)
- exc_count  output  8  overflow count; saturates at 255; cleared only by reset

## Operation
- Storage: 2 entries of {addr, data}, with head pointer, tail pointer and a 2-bit occupancy counter (0..2). Pointers wrap modulo 2.
- in_ready = (occupancy < 2). It is a function of registered occupancy only, with no pass-through of same-cycle pops. When full, in_ready=0 even if wb_ready=1.
- Accept occurs when in_valid && in_ready:
  - If in_co == 0: enqueue {in_rd_addr, in_result} at tail; tail++; occupancy++.
  - If in_co != 0: do not enqueue. Set exc_flag. Load exc_addr only if exc_flag was 0 before this cycle. Increment exc_count unless it is already 255.
- Pop occurs when wb_valid && wb_ready: head++; occupancy--.
- Simultaneous push and pop (occupancy 1): occupancy stays 1; order is preserved.
- Simultaneous overflow accept and pop: the pop proceeds normally; the overflow does not change occupancy.
- wb_valid = (occupancy != 0). wb_addr and wb_data come from the head entry.
- Producer rule: in_rd_addr, in_result and in_co must be held stable while in_valid=1 && in_ready=0.
- exc_clr:
  - With no overflow accepted in the same cycle: exc_flag goes to 0; exc_addr is held.
  - With an overflow accepted in the same cycle: the new exception wins. exc_flag stays 1 and exc_addr loads the new address.
- States (by occupancy):
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push and pop → ONE.
  - FULL: pop → ONE; push is blocked.

## Timing
- Reset (rst_n=0, asynchronous): occupancy=0, both pointers=0, wb_valid=0, wb_addr=0, wb_data=0, exc_flag=0, exc_addr=0, exc_count=0. in_ready=1 during and after reset.
- Reset mid-operation discards all buffered entries and exception state immediately, with no clock edge required.
- Latency: an entry accepted at edge k has wb_valid=1 with its data after edge k, i.e. in cycle k+1.
- Throughput: 1 result per cycle sustained while wb_ready=1.
- exc_flag, exc_addr and exc_count update at the same edge that accepts the overflowing input.
- All outputs are glitch-free functions of registers. There is no combinational path from in_* or wb_ready to any output.

## Test plan
- Reset, then accept {addr=3, result=42, co=0}: next cycle wb_valid=1, wb_addr=3, wb_data=42. Pop with wb_ready=1 → wb_valid=0, wb_addr=0, wb_data=0.
- Hold wb_ready=0 and push 3 results (5→r1, 6→r2, 7→r3): in_ready=0 after the 2nd accept and r3 stalls. Raise wb_ready: outputs are r1=5, r2=6, then r3=7 accepted and output in order.
- Accept {addr=4, result=0, co=1}: no wb_valid, exc_flag=1, exc_addr=4, exc_count=1. Then accept {addr=6, co=2}: exc_addr stays 4, exc_count=2.
- Assert exc_clr alone: exc_flag=0, exc_addr=4. Assert exc_clr in the same cycle as an overflow accept with addr=5: exc_flag=1, exc_addr=5.
- Inject 260 overflows: exc_count stops at 255. Assert rst_n=0 mid-stream with 2 entries buffered: wb_valid=0 and exc_count=0 immediately, with no clock edge.
- Occupancy 1 with push (9→r7) and pop in the same cycle: occupancy stays 1 and the next head is r7=9.
